// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the ROM read-port arbiter: requester IDs and the
// codebase-wide width/enable constants.
package rom_arbiter_pkg;

  localparam int unsigned PORT_WORD_WIDTH = 32;
  localparam int unsigned RegBus          = 32;

  localparam logic              Enable    = 1'b1;
  localparam logic              RstEnable = 1'b0;
  localparam logic [RegBus-1:0] ZeroWord  = '0;

  typedef logic req_id_t;

  localparam req_id_t REQ_IF = 1'b0;
  localparam req_id_t REQ_LS = 1'b1;

endpackage

// File: rtl/rom_arb_grant.sv
// Two-way combinational grant for the ROM read port. Fixed IF priority by default;
// with ROM_ARB_RR_EN defined, ties alternate using a last-grant pointer.
module rom_arb_grant
  import rom_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic if_valid,
  input  logic ls_valid,
  input  logic rom_ready,
  output logic if_gnt,
  output logic ls_gnt
);

`ifdef ROM_ARB_RR_EN
  req_id_t last_q, last_d;

  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (rom_ready == Enable) begin
      if (if_valid && ls_valid) begin
        // Tie goes to whoever was not granted last.
        if_gnt = (last_q == REQ_LS);
        ls_gnt = (last_q == REQ_IF);
      end else begin
        if_gnt = if_valid;
        ls_gnt = ls_valid;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (if_gnt) begin
      last_d = REQ_IF;
    end else if (ls_gnt) begin
      last_d = REQ_LS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RstEnable) begin
      last_q <= REQ_LS;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  always_comb begin
    if_gnt = rom_ready & if_valid;
    ls_gnt = rom_ready & ls_valid & ~if_valid;
  end
`endif

endmodule

// File: rtl/rom_arbiter.sv
// Shares the instruction ROM read port between IF and LS: grant, range check,
// one-cycle pending stage and response routing. Option macro: ROM_ARB_RR_EN.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = PORT_WORD_WIDTH,
  parameter int unsigned DATA_W    = RegBus,
  parameter int unsigned ROM_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  input  logic              if_flush,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              ls_req_valid,
  input  logic [ADDR_W-1:0] ls_req_addr,
  output logic              ls_req_ready,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              ls_rsp_err,
  output logic [ADDR_W-1:0] rom_pc_o,
  output logic              rom_rd_valid_o,
  input  logic              rom_rd_ready_i,
  input  logic [DATA_W-1:0] rom_inst_data_i
);

  // One extra bit so ROM_DEPTH itself is representable for the compare.
  localparam logic [ADDR_W:0] DepthExt = (ADDR_W + 1)'(ROM_DEPTH);

  logic              if_gnt, ls_gnt;
  logic              accept, in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic              if_hit, ls_hit;

  logic    pend_valid_q, pend_valid_d;
  logic    pend_err_q, pend_err_d;
  req_id_t pend_owner_q, pend_owner_d;

  rom_arb_grant u_grant (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_valid  (if_req_valid),
    .ls_valid  (ls_req_valid),
    .rom_ready (rom_rd_ready_i),
    .if_gnt    (if_gnt),
    .ls_gnt    (ls_gnt)
  );

  // Request side is gated by rst_n so every output reads 0 while in reset.
  always_comb begin
    accept         = (if_gnt | ls_gnt) & rst_n;
    sel_addr       = if_gnt ? if_req_addr : ls_req_addr;
    in_range       = ({1'b0, sel_addr} < DepthExt);
    if_req_ready   = if_gnt & rst_n;
    ls_req_ready   = ls_gnt & rst_n;
    rom_rd_valid_o = accept & in_range;
    rom_pc_o       = rom_rd_valid_o ? sel_addr : '0;
  end

  always_comb begin
    pend_valid_d = accept;
    pend_owner_d = ls_gnt ? REQ_LS : REQ_IF;
    pend_err_d   = accept & ~in_range;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RstEnable) begin
      pend_valid_q <= 1'b0;
      pend_owner_q <= REQ_IF;
      pend_err_q   <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_owner_q <= pend_owner_d;
      pend_err_q   <= pend_err_d;
    end
  end

  always_comb begin
    if_hit       = pend_valid_q & (pend_owner_q == REQ_IF) & ~if_flush;
    ls_hit       = pend_valid_q & (pend_owner_q == REQ_LS);
    if_rsp_valid = if_hit;
    if_rsp_err   = if_hit & pend_err_q;
    if_rsp_data  = (if_hit & ~pend_err_q) ? rom_inst_data_i : DATA_W'(ZeroWord);
    ls_rsp_valid = ls_hit;
    ls_rsp_err   = ls_hit & pend_err_q;
    ls_rsp_data  = (ls_hit & ~pend_err_q) ? rom_inst_data_i : DATA_W'(ZeroWord);
  end

endmodule
